// File: rtl/serial_link_pkg.sv
// Shared constants and types for the 2-bit-per-cycle DDR serial link.
package serial_link_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned LANES        = 2;
  localparam int unsigned CYC_PER_WORD = WORD_W / LANES;

  localparam logic [WORD_W-1:0] DEFAULT_SYNC_WORD = 32'hF0E1_5A3C;

  typedef enum logic [1:0] {
    StHunt,
    StConfirm,
    StLocked
  } state_e;

endpackage

// File: rtl/serial_recv_align.sv
// Bit-pair history shifter with training-word comparators at both bit alignments.
module serial_recv_align
  import serial_link_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_WORD = DEFAULT_SYNC_WORD
) (
  input  logic              CLKS,
  input  logic              RSTXS,
  input  logic [LANES-1:0]  i_din,
  output logic              o_match_even,
  output logic              o_match_odd,
  output logic [WORD_W-1:0] o_cand_even,
  output logic [WORD_W-1:0] o_cand_odd
);

  // One extra bit beyond a word is enough to see the one-bit-slipped candidate.
  logic [WORD_W:0] r_hist;

  always_ff @(posedge CLKS or negedge RSTXS) begin
    if (!RSTXS) begin
      r_hist <= '0;
    end else begin
      r_hist <= {r_hist[WORD_W-LANES:0], i_din};
    end
  end

  assign o_cand_even  = r_hist[WORD_W-1:0];
  assign o_cand_odd   = r_hist[WORD_W:1];
  assign o_match_even = (o_cand_even == SYNC_WORD);
  assign o_match_odd  = (o_cand_odd == SYNC_WORD);

endmodule

// File: rtl/serial_recv.sv
// DDR serial receiver: hunts for the training word, confirms alignment, then
// delivers one word per CYC_PER_WORD cycles.
module serial_recv
  import serial_link_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_WORD  = DEFAULT_SYNC_WORD,
  parameter int unsigned       LOCK_COUNT = 4
) (
  input  logic              CLKS,
  input  logic              RSTXS,
  input  logic [LANES-1:0]  DIN,
  input  logic              RELOCK,
  output logic [WORD_W-1:0] DOUT,
  output logic              DVALID,
  output logic              IS_SYNC,
  output logic              LOCKED,
  output logic              SLIP
);

  localparam int unsigned CNT_W    = $clog2(CYC_PER_WORD);
  localparam logic [3:0]  LOCK_CNT = 4'(LOCK_COUNT);

  logic              w_match_even;
  logic              w_match_odd;
  logic [WORD_W-1:0] w_cand_even;
  logic [WORD_W-1:0] w_cand_odd;
  logic [WORD_W-1:0] w_cand;
  logic              w_cand_match;
  logic [3:0]        w_good_inc;

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_good;
  logic              r_slip;
  logic [WORD_W-1:0] r_dout;
  logic              r_dvalid;
  logic              r_is_sync;

  state_e            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [3:0]        w_good_nxt;
  logic              w_slip_nxt;
  logic [WORD_W-1:0] w_dout_nxt;
  logic              w_dvalid_nxt;
  logic              w_is_sync_nxt;

  serial_recv_align #(
    .SYNC_WORD (SYNC_WORD)
  ) u_align (
    .CLKS         (CLKS),
    .RSTXS        (RSTXS),
    .i_din        (DIN),
    .o_match_even (w_match_even),
    .o_match_odd  (w_match_odd),
    .o_cand_even  (w_cand_even),
    .o_cand_odd   (w_cand_odd)
  );

  assign w_cand       = r_slip ? w_cand_odd : w_cand_even;
  assign w_cand_match = r_slip ? w_match_odd : w_match_even;
  assign w_good_inc   = r_good + 4'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + CNT_W'(1);
    w_good_nxt    = r_good;
    w_slip_nxt    = r_slip;
    w_dout_nxt    = r_dout;
    w_dvalid_nxt  = 1'b0;
    w_is_sync_nxt = 1'b0;
    // RELOCK wins over everything, including a coincident word boundary.
    if (RELOCK) begin
      w_state_nxt = StHunt;
    end else begin
      unique case (r_state)
        StHunt: begin
          if (w_match_even || w_match_odd) begin
            w_slip_nxt  = !w_match_even;
            w_cnt_nxt   = CNT_W'(1);
            w_good_nxt  = 4'd1;
            w_state_nxt = (LOCK_COUNT == 1) ? StLocked : StConfirm;
          end
        end
        StConfirm: begin
          if (r_cnt == '0) begin
            if (w_cand_match) begin
              w_good_nxt = w_good_inc;
              if (w_good_inc == LOCK_CNT) begin
                w_state_nxt = StLocked;
              end
            end else begin
              w_state_nxt = StHunt;
            end
          end
        end
        StLocked: begin
          if (r_cnt == '0) begin
            w_dout_nxt    = w_cand;
            w_dvalid_nxt  = 1'b1;
            w_is_sync_nxt = w_cand_match;
          end
        end
        default: begin
          w_state_nxt = StHunt;
        end
      endcase
    end
  end

  always_ff @(posedge CLKS or negedge RSTXS) begin
    if (!RSTXS) begin
      r_state   <= StHunt;
      r_cnt     <= '0;
      r_good    <= '0;
      r_slip    <= 1'b0;
      r_dout    <= '0;
      r_dvalid  <= 1'b0;
      r_is_sync <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_good    <= w_good_nxt;
      r_slip    <= w_slip_nxt;
      r_dout    <= w_dout_nxt;
      r_dvalid  <= w_dvalid_nxt;
      r_is_sync <= w_is_sync_nxt;
    end
  end

  assign DOUT    = r_dout;
  assign DVALID  = r_dvalid;
  assign IS_SYNC = r_is_sync;
  assign LOCKED  = (r_state == StLocked);
  assign SLIP    = r_slip;

endmodule
